// File: rtl/fifo_stream_reader_if.sv
// FIFO read port and output stream of the FIFO stream reader.
// master = reader side; slave = the FIFO/sink environment.
interface fifo_stream_reader_if #(
    parameter int pDATA_WIDTH = 8
);
    logic                   fifo_ren;
    logic [pDATA_WIDTH-1:0] fifo_rdata;
    logic                   fifo_empty;
    logic                   fifo_underflow;
    logic                   m_valid;
    logic                   m_ready;
    logic [pDATA_WIDTH-1:0] m_data;
    logic                   m_last;

    modport master (
        output fifo_ren, m_valid, m_data, m_last,
        input  fifo_rdata, fifo_empty, fifo_underflow, m_ready
    );

    modport slave (
        input  fifo_ren, m_valid, m_data, m_last,
        output fifo_rdata, fifo_empty, fifo_underflow, m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Reads burst_len words from a 1-cycle-latency FIFO into a valid/ready stream; first word 3 cycles after start.
// A 2-entry buffer absorbs sink stalls; FIFO_READER_STATS_EN adds word/stall counters.
module fifo_stream_reader #(
    parameter int pDATA_WIDTH  = 8,
    parameter int pBURST_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [pBURST_WIDTH-1:0] burst_len,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             stat_words,
    output logic [31:0]             stat_stalls,
    fifo_stream_reader_if.master    bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                  state_q, state_nxt;
    logic [pBURST_WIDTH-1:0] req_left_q, out_left_q;
    logic [1:0]              occ_q;
    logic                    inflight_q;
    logic                    error_q;
    logic [pDATA_WIDTH-1:0]  buf_q [2];

    logic ren, out_vld, out_last, pop, start_acc, space_ok, wr_idx;

    assign out_vld   = (occ_q != 2'd0);
    assign out_last  = out_vld && (out_left_q == pBURST_WIDTH'(1));
    assign pop       = out_vld && bus.m_ready;
    assign start_acc = start && (state_q == ST_IDLE);
    // A word popped this cycle frees a slot for a read issued this cycle.
    assign space_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    // Arriving word lands behind whatever survives this cycle's pop.
    assign wr_idx    = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_nxt = (burst_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (ren && (req_left_q == pBURST_WIDTH'(1))) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop && out_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        ren  = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy = 1'b1;
                ren  = !bus.fifo_empty && (req_left_q != '0) && space_ok;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_left_q <= '0;
            out_left_q <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
            inflight_q <= ren;
            if (start_acc) begin
                req_left_q <= burst_len;
                out_left_q <= burst_len;
                error_q    <= 1'b0;
            end else begin
                if (ren) req_left_q <= req_left_q - pBURST_WIDTH'(1);
                if (pop) out_left_q <= out_left_q - pBURST_WIDTH'(1);
                if (bus.fifo_underflow && busy) error_q <= 1'b1;
            end
        end
    end

    // Payload needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (pop)        buf_q[0]      <= buf_q[1];
        if (inflight_q) buf_q[wr_idx] <= bus.fifo_rdata;
    end

    assign bus.fifo_ren = ren;
    assign bus.m_valid  = out_vld;
    assign bus.m_data   = buf_q[0];
    assign bus.m_last   = out_last;
    assign error        = error_q;

`ifdef FIFO_READER_STATS_EN
    logic [31:0] words_q, stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q  <= '0;
            stalls_q <= '0;
        end else if (start_acc) begin
            words_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (pop && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
            if (out_vld && !bus.m_ready && (stalls_q != 32'hFFFF_FFFF)) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign stat_words  = words_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_words  = '0;
    assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench: queue-based FIFO and expected-stream model, checked every cycle.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          busy, done, error;
    logic [31:0]   stat_words, stat_stalls;

    fifo_stream_reader_if #(.pDATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.pDATA_WIDTH(DW), .pBURST_WIDTH(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .stat_words  (stat_words),
        .stat_stalls (stat_stalls),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int cur_len, words_acc, issued, stalls, rel;
    int done_cnt, done_rel, last_acc_rel, first_vld_rel;
    bit hold_pend, err_exp;
    logic [DW-1:0] hold_dat;
    logic hold_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", tag, obs, exp, rel);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    function automatic bit ready_for(input int mode, input int r);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (r % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // One clock: drive at negedge, observe 1ns later, update the FIFO/stream model, advance past posedge.
    task automatic cycle(input bit st, input bit rdy, input bit uf);
        logic [DW-1:0] rd_next;
        bit do_ren, vld, lst;
        logic [DW-1:0] dat;
        rd_next = '0;
        @(negedge clk);
        start              = st;
        bus.m_ready        = rdy;
        bus.fifo_underflow = uf;
        bus.fifo_empty     = (fifo_q.size() == 0);
        #1;
        vld = bus.m_valid;
        dat = bus.m_data;
        lst = bus.m_last;
        chk("ren_while_empty", {31'd0, bus.fifo_ren & bus.fifo_empty}, 0);
        chk("error", {31'd0, error}, {31'd0, err_exp});
        chk("outstanding_le2", {31'd0, (issued - words_acc) <= 2}, 1);
        if (!vld) chk("last_without_valid", {31'd0, lst}, 0);
        if (st) chk("busy_before_start", {31'd0, busy}, 0);
        if (!st && rel >= 1 && words_acc < cur_len) chk("busy_in_burst", {31'd0, busy}, 1);
        if (hold_pend) begin
            chk("hold_valid", {31'd0, vld}, 1);
            chk("hold_data", {24'd0, dat}, {24'd0, hold_dat});
            chk("hold_last", {31'd0, lst}, {31'd0, hold_last});
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
            chk("done_after_all_words", words_acc, cur_len);
            chk("busy_at_done", {31'd0, busy}, 0);
        end
        if (vld && first_vld_rel < 0) first_vld_rel = rel;
        if (vld && rdy) begin
            if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
            else chk("data", {24'd0, dat}, {24'd0, exp_q.pop_front()});
            chk("last", {31'd0, lst}, {31'd0, (words_acc + 1) == cur_len});
            words_acc++;
            last_acc_rel = rel;
        end else if (vld) begin
            stalls++;
        end
        hold_pend = vld && !rdy;
        hold_dat  = dat;
        hold_last = lst;
        if (bus.fifo_ren) issued++;
        do_ren = bus.fifo_ren && (fifo_q.size() != 0);
        if (do_ren) rd_next = fifo_q.pop_front();
        @(posedge clk);
        #1;
        start              = 1'b0;
        bus.fifo_underflow = 1'b0;
        if (do_ren) bus.fifo_rdata = rd_next;
        if (st) err_exp = 1'b0;
        else if (uf) err_exp = 1'b1;
        rel++;
    endtask

    task automatic clear_burst_model(input int len);
        cur_len = len; words_acc = 0; issued = 0; stalls = 0; rel = 0;
        done_cnt = 0; done_rel = -1; last_acc_rel = -1; first_vld_rel = -1;
        hold_pend = 1'b0;
    endtask

    // Runs one burst; late_n words are pushed into the FIFO at rel cycle late_at.
    task automatic run_burst(input int len, input int mode, input int late_n, input int late_at,
                             input int uf_at, input bit lat_chk);
        clear_burst_model(len);
        burst_len = BW'(len);
        cycle(1'b1, ready_for(mode, 0), 1'b0);
        while (done_cnt == 0 && rel < 300) begin
            if (rel == late_at)
                for (int i = 0; i < late_n; i++) push_word(DW'($urandom));
            cycle(1'b0, ready_for(mode, rel), rel == uf_at);
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("done_once", done_cnt, 1);
        chk("words_delivered", words_acc, len);
        chk("reads_issued", issued, len);
        if (len > 0) chk("done_after_last", {31'd0, (done_rel - last_acc_rel) inside {1, 2}}, 1);
        else chk("done_zero_len", {31'd0, done_rel inside {1, 2}}, 1);
        if (lat_chk) begin
            chk("first_valid_latency", first_vld_rel, 3);
            chk("back_to_back", last_acc_rel, 2 + len);
        end
`ifdef FIFO_READER_STATS_EN
        chk("stat_words", stat_words, len);
        chk("stat_stalls", stat_stalls, stalls);
`else
        chk("stat_words_off", stat_words, 0);
        chk("stat_stalls_off", stat_stalls, 0);
`endif
    endtask

    initial begin
        int len, pre;
        bus.fifo_rdata     = '0;
        bus.fifo_empty     = 1'b1;
        bus.fifo_underflow = 1'b0;
        bus.m_ready        = 1'b0;
        err_exp            = 1'b0;
        clear_burst_model(0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_valid", {31'd0, bus.m_valid}, 0);
        chk("rst_last", {31'd0, bus.m_last}, 0);
        chk("rst_ren", {31'd0, bus.fifo_ren}, 0);
        chk("rst_stat_words", stat_words, 0);
        chk("rst_stat_stalls", stat_stalls, 0);
        rst_n = 1'b1;

        // 8 prefilled words, sink always ready
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
        run_burst(8, 0, 0, -1, -1, 1'b1);

        // Same with alternating ready
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
        run_burst(8, 1, 0, -1, -1, 1'b0);

        // Zero-length burst
        run_burst(0, 0, 0, -1, -1, 1'b0);

        // FIFO runs dry mid-burst; 2 words arrive 10 cycles later
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        run_burst(5, 0, 2, 10, -1, 1'b0);

        // Underflow while busy sets a sticky error; next start clears it
        for (int i = 0; i < 6; i++) push_word(DW'($urandom));
        run_burst(6, 2, 0, -1, 2, 1'b0);
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        run_burst(4, 2, 0, -1, -1, 1'b0);

        // Reset with the output buffer full
        for (int i = 0; i < 6; i++) push_word(DW'($urandom));
        clear_burst_model(6);
        burst_len = BW'(6);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("buffer_full_before_reset", {31'd0, bus.m_valid}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_valid", {31'd0, bus.m_valid}, 0);
        chk("mid_rst_last", {31'd0, bus.m_last}, 0);
        chk("mid_rst_ren", {31'd0, bus.fifo_ren}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_stat_words", stat_words, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        err_exp = 1'b0;
        push_word(8'hA5);
        push_word(8'h5A);
        run_burst(2, 0, 0, -1, -1, 1'b0);

        // Random bursts: random lengths, partial prefill, late arrivals, random ready
        for (int b = 0; b < 10; b++) begin
            len = $urandom_range(1, 12);
            pre = $urandom_range(0, len);
            for (int i = 0; i < pre; i++) push_word(DW'($urandom));
            run_burst(len, 2, len - pre, $urandom_range(2, 15), -1, 1'b0);
        end
        for (int i = 0; i < 40; i++) push_word(DW'($urandom));
        run_burst(40, 2, 0, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
